// File: rtl/parse_sign.sv
// parse_sign: splits a serialized signature into its per-party fields.
//
// A parse captures sigma and the four opened-party indices (lc), then walks
// parties 0..7 one per cycle. Opened parties take the next Z[kz] record
// (seed, masked_key, msgs, C, seed_lambda, aux_triangle). Unopened parties
// take the next iSeedInfo[ko] / cvInfo[ko] pair (seed_star, Cv).
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   parse_sign_start    level request; a new parse needs start low for a cycle
//   lc[19:0]            four 5-bit opened indices, entry 0 in bits [19:15]
//   sigma[21632-1:0]    h_t | salt | iSeedInfo[0..3] | cvInfo[0..3] | Z[0..3] | seed_triangle
//   h_t_o, salt_o, seed_triangle_o   global fields, valid from the cycle after capture
//   seed_star_o .. aux_triangle_o    per-party fields, party 0 in the top slot
//   opened_mask         bit 7-p set when party p is opened
//   parse_err           duplicate / out-of-range index or nonzero reserved field
//   parse_sign_end      done; held while start stays high
module parse_sign (
  input  logic           clk,
  input  logic           reset,
  input  logic           parse_sign_start,
  input  logic [19:0]    lc,
  input  logic [21631:0] sigma,
  output logic [255:0]   h_t_o,
  output logic [255:0]   salt_o,
  output logic [127:0]   seed_triangle_o,
  output logic [1023:0]  seed_star_o,
  output logic [2047:0]  Cv_o,
  output logic [15359:0] seed_o,
  output logic [1023:0]  masked_key_o,
  output logic [4095:0]  msgs_o,
  output logic [2047:0]  C_o,
  output logic [4095:0]  seed_lambda_o,
  output logic [8191:0]  aux_triangle_o,
  output logic [7:0]     opened_mask,
  output logic           parse_err,
  output logic           parse_sign_end
);

  localparam int unsigned NP     = 8;
  localparam int unsigned HT_W   = 256;
  localparam int unsigned SALT_W = 256;
  localparam int unsigned IS_W   = 128;
  localparam int unsigned CV_W   = 256;
  localparam int unsigned ZW     = 4864;
  localparam int unsigned TRI_W  = 128;

  // Fields inside one Z record, offsets from its LSB.
  localparam int unsigned AUX_W  = 1024;
  localparam int unsigned SL_W   = 512;
  localparam int unsigned C_W    = 256;
  localparam int unsigned MSG_W  = 512;
  localparam int unsigned MK_W   = 128;
  localparam int unsigned SEED_W = 1920;
  localparam int unsigned RES_W  = 512;
  localparam int unsigned Z_AUX  = 0;
  localparam int unsigned Z_SL   = Z_AUX + AUX_W;
  localparam int unsigned Z_C    = Z_SL + SL_W;
  localparam int unsigned Z_MSG  = Z_C + C_W;
  localparam int unsigned Z_MK   = Z_MSG + MSG_W;
  localparam int unsigned Z_SEED = Z_MK + MK_W;
  localparam int unsigned Z_RES  = Z_SEED + SEED_W;

  // sigma offsets from its LSB; the "body" is everything between
  // seed_triangle and salt, which is the only part needed after capture.
  localparam int unsigned OFF_TRI  = 0;
  localparam int unsigned OFF_BODY = OFF_TRI + TRI_W;
  localparam int unsigned BODY_W   = 4 * ZW + 4 * CV_W + 4 * IS_W;
  localparam int unsigned OFF_SALT = OFF_BODY + BODY_W;
  localparam int unsigned OFF_HT   = OFF_SALT + SALT_W;

  // Offsets inside the body; record 0 of each group is the most significant.
  localparam int unsigned B_Z  = 0;
  localparam int unsigned B_CV = B_Z + 4 * ZW;
  localparam int unsigned B_IS = B_CV + 4 * CV_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SCATTER = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t            state;
  logic [BODY_W-1:0] body_q;
  logic [19:0]       lc_q;
  logic [2:0]        j;
  logic [2:0]        ko;
  logic [2:0]        kz;

  logic [ZW-1:0]     z_cur_c;
  logic [IS_W-1:0]   is_cur_c;
  logic [CV_W-1:0]   cv_cur_c;
  logic              opened_c;
  logic              lc_range_err_c;

  // Z record selected by kz (kz=4 never loads, so it aliases record 0 harmlessly).
  always_comb begin
    z_cur_c = '0;
    case (kz[1:0])
      2'd0:    z_cur_c = body_q[B_Z + 3 * ZW +: ZW];
      2'd1:    z_cur_c = body_q[B_Z + 2 * ZW +: ZW];
      2'd2:    z_cur_c = body_q[B_Z + 1 * ZW +: ZW];
      default: z_cur_c = body_q[B_Z +: ZW];
    endcase
  end

  // iSeedInfo / cvInfo pair selected by ko.
  always_comb begin
    is_cur_c = '0;
    cv_cur_c = '0;
    case (ko[1:0])
      2'd0: begin
        is_cur_c = body_q[B_IS + 3 * IS_W +: IS_W];
        cv_cur_c = body_q[B_CV + 3 * CV_W +: CV_W];
      end
      2'd1: begin
        is_cur_c = body_q[B_IS + 2 * IS_W +: IS_W];
        cv_cur_c = body_q[B_CV + 2 * CV_W +: CV_W];
      end
      2'd2: begin
        is_cur_c = body_q[B_IS + 1 * IS_W +: IS_W];
        cv_cur_c = body_q[B_CV + 1 * CV_W +: CV_W];
      end
      default: begin
        is_cur_c = body_q[B_IS +: IS_W];
        cv_cur_c = body_q[B_CV +: CV_W];
      end
    endcase
  end

  // Current party is opened if any captured index names it.
  always_comb begin
    opened_c = (lc_q[19:15] == {2'b00, j}) || (lc_q[14:10] == {2'b00, j}) ||
               (lc_q[9:5]   == {2'b00, j}) || (lc_q[4:0]   == {2'b00, j});
  end

  // An index of 8 or more has a nonzero upper pair of bits.
  always_comb begin
    lc_range_err_c = |{lc[19:18], lc[14:13], lc[9:8], lc[4:3]};
  end

  // Parse sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      j               <= '0;
      ko              <= '0;
      kz              <= '0;
      h_t_o           <= '0;
      salt_o          <= '0;
      seed_triangle_o <= '0;
      seed_star_o     <= '0;
      Cv_o            <= '0;
      seed_o          <= '0;
      masked_key_o    <= '0;
      msgs_o          <= '0;
      C_o             <= '0;
      seed_lambda_o   <= '0;
      aux_triangle_o  <= '0;
      opened_mask     <= '0;
      parse_err       <= 1'b0;
      parse_sign_end  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (parse_sign_start && !parse_sign_end) begin
            state <= CAPTURE;
          end
        end

        CAPTURE: begin
          body_q          <= sigma[OFF_BODY +: BODY_W];
          lc_q            <= lc;
          h_t_o           <= sigma[OFF_HT +: HT_W];
          salt_o          <= sigma[OFF_SALT +: SALT_W];
          seed_triangle_o <= sigma[OFF_TRI +: TRI_W];
          seed_star_o     <= '0;
          Cv_o            <= '0;
          seed_o          <= '0;
          masked_key_o    <= '0;
          msgs_o          <= '0;
          C_o             <= '0;
          seed_lambda_o   <= '0;
          aux_triangle_o  <= '0;
          opened_mask     <= '0;
          parse_err       <= lc_range_err_c;
          j               <= '0;
          ko              <= '0;
          kz              <= '0;
          state           <= SCATTER;
        end

        SCATTER: begin
          // Once a pool is exhausted the party is a duplicate: flag it, leave slots zero.
          if (opened_c) begin
            if (!kz[2]) begin
              for (int p = 0; p < NP; p++) begin
                if (3'(p) == j) begin
                  seed_o[(NP - 1 - p) * SEED_W +: SEED_W]        <= z_cur_c[Z_SEED +: SEED_W];
                  masked_key_o[(NP - 1 - p) * MK_W +: MK_W]      <= z_cur_c[Z_MK +: MK_W];
                  msgs_o[(NP - 1 - p) * MSG_W +: MSG_W]          <= z_cur_c[Z_MSG +: MSG_W];
                  C_o[(NP - 1 - p) * C_W +: C_W]                 <= z_cur_c[Z_C +: C_W];
                  seed_lambda_o[(NP - 1 - p) * SL_W +: SL_W]     <= z_cur_c[Z_SL +: SL_W];
                  aux_triangle_o[(NP - 1 - p) * AUX_W +: AUX_W]  <= z_cur_c[Z_AUX +: AUX_W];
                  opened_mask[NP - 1 - p]                        <= 1'b1;
                end
              end
              if (|z_cur_c[Z_RES +: RES_W]) begin
                parse_err <= 1'b1;
              end
              kz <= kz + 3'd1;
            end else begin
              parse_err <= 1'b1;
            end
          end else begin
            if (!ko[2]) begin
              for (int p = 0; p < NP; p++) begin
                if (3'(p) == j) begin
                  seed_star_o[(NP - 1 - p) * IS_W +: IS_W] <= is_cur_c;
                  Cv_o[(NP - 1 - p) * CV_W +: CV_W]        <= cv_cur_c;
                end
              end
              ko <= ko + 3'd1;
            end else begin
              parse_err <= 1'b1;
            end
          end

          j <= j + 3'd1;
          if (j == 3'd7) begin
            state          <= DONE;
            parse_sign_end <= 1'b1;
          end
        end

        DONE: begin
          if (!parse_sign_start) begin
            parse_sign_end <= 1'b0;
            state          <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_parse_sign.sv
// Directed bench for parse_sign: builds sigma from known field patterns,
// runs parses with several lc sets and checks every slot against the
// hand-derived party-to-record mapping.
module tb_parse_sign;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [19:0]    lc;
  logic [21631:0] sigma;
  logic [255:0]   h_t_o;
  logic [255:0]   salt_o;
  logic [127:0]   seed_triangle_o;
  logic [1023:0]  seed_star_o;
  logic [2047:0]  Cv_o;
  logic [15359:0] seed_o;
  logic [1023:0]  masked_key_o;
  logic [4095:0]  msgs_o;
  logic [2047:0]  C_o;
  logic [4095:0]  seed_lambda_o;
  logic [8191:0]  aux_triangle_o;
  logic [7:0]     opened_mask;
  logic           parse_err;
  logic           parse_sign_end;

  parse_sign dut (
    .clk             (clk),
    .reset           (reset),
    .parse_sign_start(start),
    .lc              (lc),
    .sigma           (sigma),
    .h_t_o           (h_t_o),
    .salt_o          (salt_o),
    .seed_triangle_o (seed_triangle_o),
    .seed_star_o     (seed_star_o),
    .Cv_o            (Cv_o),
    .seed_o          (seed_o),
    .masked_key_o    (masked_key_o),
    .msgs_o          (msgs_o),
    .C_o             (C_o),
    .seed_lambda_o   (seed_lambda_o),
    .aux_triangle_o  (aux_triangle_o),
    .opened_mask     (opened_mask),
    .parse_err       (parse_err),
    .parse_sign_end  (parse_sign_end)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Source fields used to build sigma.
  logic [255:0]  ht, salt;
  logic [127:0]  tri_s;
  logic [127:0]  iseed [4];
  logic [255:0]  cv    [4];
  logic [511:0]  zres  [4];
  logic [1919:0] zseed [4];
  logic [127:0]  zmk   [4];
  logic [511:0]  zmsg  [4];
  logic [255:0]  zc    [4];
  logic [511:0]  zsl   [4];
  logic [1023:0] zaux  [4];

  task automatic check(input string tag, input logic [2047:0] got, input logic [2047:0] exp);
    int d;
    n_cmp++;
    if (got !== exp) begin
      d = -1;
      for (int b = 2047; b >= 0; b--) if (d < 0 && got[b] !== exp[b]) d = b;
      n_bad++;
      $display("FAIL %s: got[63:0]=%h expected[63:0]=%h first differing bit %0d",
               tag, got[63:0], exp[63:0], d);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2047:0] pat(input int unsigned id);
    logic [2047:0] r;
    for (int w = 0; w < 64; w++) r[w*32 +: 32] = {16'(id), 16'(w)} ^ 32'h9E37_0000;
    return r;
  endfunction

  task automatic fill(input int unsigned base);
    ht    = 256'(pat(base + 1));
    salt  = 256'(pat(base + 2));
    tri_s = 128'(pat(base + 3));
    for (int i = 0; i < 4; i++) begin
      iseed[i] = 128'(pat(base + 10 + i));
      cv[i]    = 256'(pat(base + 20 + i));
      zres[i]  = '0;
      zseed[i] = 1920'(pat(base + 30 + i));
      zmk[i]   = 128'(pat(base + 40 + i));
      zmsg[i]  = 512'(pat(base + 50 + i));
      zc[i]    = 256'(pat(base + 60 + i));
      zsl[i]   = 512'(pat(base + 70 + i));
      zaux[i]  = 1024'(pat(base + 80 + i));
    end
  endtask

  function automatic logic [4863:0] zword(input int k);
    return {zres[k], zseed[k], zmk[k], zmsg[k], zc[k], zsl[k], zaux[k]};
  endfunction

  task automatic pack;
    sigma = {ht, salt, iseed[0], iseed[1], iseed[2], iseed[3],
             cv[0], cv[1], cv[2], cv[3],
             zword(0), zword(1), zword(2), zword(3), tri_s};
  endtask

  function automatic logic [19:0] mk_lc(input int a, input int b, input int c, input int d);
    return {5'(a), 5'(b), 5'(c), 5'(d)};
  endfunction

  // Start is already high before the first edge; end must rise exactly at edge 10.
  task automatic end_timing(input string tag);
    repeat (9) tick;
    check({tag, "_end_e9"}, 2048'(parse_sign_end), 2048'(0));
    tick;
    check({tag, "_end_e10"}, 2048'(parse_sign_end), 2048'(1));
  endtask

  // zm[p]: Z record expected in party p (-1 none); om[p]: iSeed/cv index (-1 none).
  task automatic check_parties(input string tag, input int zm[8], input int om[8]);
    for (int p = 0; p < 8; p++) begin
      int k;
      int o;
      k = zm[p];
      o = om[p];
      if (k >= 0) begin
        check($sformatf("%s_p%0d_seed", tag, p), 2048'(seed_o[(7-p)*1920 +: 1920]), 2048'(zseed[k]));
        check($sformatf("%s_p%0d_mk", tag, p), 2048'(masked_key_o[(7-p)*128 +: 128]), 2048'(zmk[k]));
        check($sformatf("%s_p%0d_msgs", tag, p), 2048'(msgs_o[(7-p)*512 +: 512]), 2048'(zmsg[k]));
        check($sformatf("%s_p%0d_C", tag, p), 2048'(C_o[(7-p)*256 +: 256]), 2048'(zc[k]));
        check($sformatf("%s_p%0d_sl", tag, p), 2048'(seed_lambda_o[(7-p)*512 +: 512]), 2048'(zsl[k]));
        check($sformatf("%s_p%0d_aux", tag, p), 2048'(aux_triangle_o[(7-p)*1024 +: 1024]), 2048'(zaux[k]));
      end else begin
        check($sformatf("%s_p%0d_zfields_zero", tag, p),
              2048'({|seed_o[(7-p)*1920 +: 1920], |masked_key_o[(7-p)*128 +: 128],
                     |msgs_o[(7-p)*512 +: 512], |C_o[(7-p)*256 +: 256],
                     |seed_lambda_o[(7-p)*512 +: 512], |aux_triangle_o[(7-p)*1024 +: 1024]}),
              2048'(0));
      end
      if (o >= 0) begin
        check($sformatf("%s_p%0d_sstar", tag, p), 2048'(seed_star_o[(7-p)*128 +: 128]), 2048'(iseed[o]));
        check($sformatf("%s_p%0d_cv", tag, p), 2048'(Cv_o[(7-p)*256 +: 256]), 2048'(cv[o]));
      end else begin
        check($sformatf("%s_p%0d_ofields_zero", tag, p),
              2048'({|seed_star_o[(7-p)*128 +: 128], |Cv_o[(7-p)*256 +: 256]}), 2048'(0));
      end
    end
  endtask

  function automatic logic [13:0] any_out();
    return {|h_t_o, |salt_o, |seed_triangle_o, |seed_star_o, |Cv_o, |seed_o, |masked_key_o,
            |msgs_o, |C_o, |seed_lambda_o, |aux_triangle_o, |opened_mask, parse_err, parse_sign_end};
  endfunction

  initial begin
    reset = 1'b1;
    start = 1'b0;
    lc    = '0;
    sigma = '0;
    tick;
    tick;
    check("reset_outputs_zero", 2048'(any_out()), 2048'(0));
    reset = 1'b0;
    tick;

    // Basic parse; sigma/lc are corrupted after capture and must not matter.
    fill(0);
    pack;
    lc    = mk_lc(0, 2, 5, 7);
    start = 1'b1;
    tick;
    check("t1_end_e1", 2048'(parse_sign_end), 2048'(0));
    tick;
    check("t1_ht", 2048'(h_t_o), 2048'(ht));
    check("t1_salt", 2048'(salt_o), 2048'(salt));
    check("t1_tri", 2048'(seed_triangle_o), 2048'(tri_s));
    check("t1_mask_cleared", 2048'(opened_mask), 2048'(0));
    sigma = ~sigma;
    lc    = 20'hFFFFF;
    repeat (7) tick;
    check("t1_end_e9", 2048'(parse_sign_end), 2048'(0));
    tick;
    check("t1_end_e10", 2048'(parse_sign_end), 2048'(1));
    check("t1_mask", 2048'(opened_mask), 2048'(8'hA5));
    check("t1_err", 2048'(parse_err), 2048'(0));
    check("t1_p1_sstar", 2048'(seed_star_o[6*128 +: 128]), 2048'(iseed[0]));
    check("t1_p6_cv", 2048'(Cv_o[1*256 +: 256]), 2048'(cv[3]));
    check("t1_p5_aux", 2048'(aux_triangle_o[2*1024 +: 1024]), 2048'(zaux[2]));
    check("t1_p1_seed_zero", 2048'(seed_o[6*1920 +: 1920]), 2048'(0));
    check("t1_ht_after", 2048'(h_t_o), 2048'(ht));
    check_parties("t1", '{0, -1, 1, -1, -1, 2, -1, 3}, '{-1, 0, -1, 1, 2, -1, 3, -1});

    // Start held: outputs stay, no second parse.
    repeat (3) tick;
    check("hold_end", 2048'(parse_sign_end), 2048'(1));
    check("hold_mask", 2048'(opened_mask), 2048'(8'hA5));
    check("hold_p0_seed", 2048'(seed_o[7*1920 +: 1920]), 2048'(zseed[0]));
    start = 1'b0;
    tick;
    check("drop_end", 2048'(parse_sign_end), 2048'(0));
    check("drop_mask_held", 2048'(opened_mask), 2048'(8'hA5));

    // Duplicate index: party 7 finds the unopened pool exhausted.
    fill(100);
    pack;
    lc    = mk_lc(1, 1, 3, 4);
    start = 1'b1;
    end_timing("t2");
    check("t2_err", 2048'(parse_err), 2048'(1));
    check("t2_mask", 2048'(opened_mask), 2048'(8'h58));
    check("t2_ht", 2048'(h_t_o), 2048'(ht));
    check_parties("t2", '{-1, 0, -1, 1, 2, -1, -1, -1}, '{0, -1, 1, -1, -1, 2, 3, -1});
    start = 1'b0;
    tick;

    // Out-of-range index, start dropped mid-parse: end still pulses once.
    fill(200);
    pack;
    lc    = mk_lc(0, 1, 2, 9);
    start = 1'b1;
    repeat (3) tick;
    start = 1'b0;
    repeat (6) tick;
    check("t3_end_e9", 2048'(parse_sign_end), 2048'(0));
    tick;
    check("t3_end_e10", 2048'(parse_sign_end), 2048'(1));
    tick;
    check("t3_end_e11", 2048'(parse_sign_end), 2048'(0));
    check("t3_err", 2048'(parse_err), 2048'(1));
    check("t3_mask", 2048'(opened_mask), 2048'(8'hE0));
    check_parties("t3", '{0, 1, 2, -1, -1, -1, -1, -1}, '{-1, -1, -1, 0, 1, 2, 3, -1});

    // Nonzero reserved field in Z[1].
    fill(300);
    zres[1] = 512'd1;
    pack;
    lc    = mk_lc(0, 1, 2, 3);
    start = 1'b1;
    end_timing("t4");
    check("t4_err", 2048'(parse_err), 2048'(1));
    check("t4_mask", 2048'(opened_mask), 2048'(8'hF0));
    check("t4_p1_seed", 2048'(seed_o[6*1920 +: 1920]), 2048'(zseed[1]));
    start = 1'b0;
    tick;

    // Reset at SCATTER j=4, then a full restart with start held.
    fill(400);
    pack;
    lc    = mk_lc(0, 2, 5, 7);
    start = 1'b1;
    repeat (6) tick;
    check("t5_mid_mask_partial", 2048'(opened_mask), 2048'(8'hA0));
    reset = 1'b1;
    tick;
    check("t5_reset_outputs_zero", 2048'(any_out()), 2048'(0));
    reset = 1'b0;
    end_timing("t5");
    check("t5_mask", 2048'(opened_mask), 2048'(8'hA5));
    check("t5_err", 2048'(parse_err), 2048'(0));
    check_parties("t5", '{0, -1, 1, -1, -1, 2, -1, 3}, '{-1, 0, -1, 1, 2, -1, 3, -1});
    start = 1'b0;
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/parse_sign.md
PARSE_SIGN -- requirements
Module: parse_sign

Interface
REQ-001 SHALL have one clock; reset is synchronous and active-high.
REQ-002 Ports, in order: name, direction, width, meaning.
- clk, in, 1, rising-edge clock.
- reset, in, 1, synchronous active-high reset.
- parse_sign_start, in, 1, level request.
- lc, in, 20, four 5-bit opened-party indices; LC0 is bits [19:15], LC3 is bits [4:0].
- sigma, in, 21632, serialized signature.
- h_t_o, out, 256.
- salt_o, out, 256.
- seed_triangle_o, out, 128.
- seed_star_o, out, 128*8.
- Cv_o, out, 256*8.
- seed_o, out, 1920*8.
- masked_key_o, out, 128*8.
- msgs_o, out, 512*8.
- C_o, out, 256*8.
- seed_lambda_o, out, 512*8.
- aux_triangle_o, out, 1024*8.
- opened_mask, out, 8, bit 7-p set when party p is opened.
- parse_err, out, 1, format error.
- parse_sign_end, out, 1, done.
REQ-003 Every per-party output SHALL be packed with party 0 in the most-significant slot and party 7 in the least-significant slot.

Function
REQ-004 sigma layout, MSB to LSB, SHALL be:
- h_t (256 bits)
- salt (256 bits)
- iSeedInfo[0..3] (128 bits each)
- cvInfo[0..3] (256 bits each)
- Z[0..3] (4864 bits each)
- seed_triangle (128 bits)
REQ-005 Z[k] layout, MSB to LSB, SHALL be:
- reserved (512 bits, must be zero)
- seed (1920 bits)
- masked_key (128 bits)
- msgs (512 bits)
- C (256 bits)
- seed_lambda (512 bits)
- aux_triangle (1024 bits)
REQ-006 States SHALL be IDLE, CAPTURE, SCATTER and DONE.
REQ-007 IDLE → CAPTURE when parse_sign_start=1 and parse_sign_end=0.
REQ-008 CAPTURE SHALL register sigma and lc into internal copies, clear all outputs except parse_sign_end, clear party index j and counters ko/kz, then go to SCATTER.
- sigma/lc changes after CAPTURE SHALL have no effect.
REQ-009 SCATTER SHALL process one party j per cycle, j = 0..7.
- Party j is opened if j equals any LC entry.
REQ-010 For an opened party, while kz<4:
- seed, masked_key, msgs, C, seed_lambda and aux_triangle slots j SHALL load from Z[kz].
- opened_mask bit 7-j SHALL be set.
- kz SHALL increment.
REQ-011 For an unopened party, while ko<4:
- seed_star slot j SHALL load iSeedInfo[ko].
- Cv slot j SHALL load cvInfo[ko].
- ko SHALL increment.
REQ-012 Per-party fields not written for a party SHALL remain zero.
REQ-013 After j=7, the state SHALL go to DONE and assert parse_sign_end.
- h_t_o, salt_o and seed_triangle_o SHALL be valid from CAPTURE+1.
REQ-014 parse_sign_end SHALL rise on the 10th rising edge after the first edge where start=1 was sampled in IDLE.
REQ-015 DONE SHALL hold all outputs while parse_sign_start=1.
- When start=0, parse_sign_end SHALL go to 0 on the next edge and the state SHALL go to IDLE; outputs hold their values.
- A new parse requires start to be low for at least one cycle.
REQ-016 parse_err SHALL be set, and stay set until the next CAPTURE or reset, when any of the following occurs:
- an opened party is seen with kz=4, or an unopened party with ko=4 (duplicate LC entries); that party's slots stay zero.
- any LC entry is ≥8.
- any used Z[k] has a nonzero reserved field.
REQ-017 parse_err SHALL NOT alter sequencing or latency.
REQ-018 Deasserting parse_sign_start during CAPTURE or SCATTER SHALL NOT abort the parse.
- DONE is reached and parse_sign_end pulses for one cycle.

Reset
REQ-019 reset=1 at a clock edge SHALL force:
- state IDLE
- j, ko and kz to 0
- all outputs to 0, including parse_sign_end, parse_err and opened_mask.
REQ-020 reset SHALL take priority over every other input, including mid-SCATTER.

Verification
REQ-021 lc={0,2,5,7}, distinct field patterns, start held → opened_mask=8'hA5, end high at edge 10, parse_err=0.
- Party 1 seed_star = iSeedInfo[0]; party 6 Cv = cvInfo[3].
- Party 5 aux_triangle = Z[2] aux; party 1 seed = 0.
REQ-022 Round trip: components packed into sigma in the same LC order and field order, then parsed → every opened and unopened field equals the original.
REQ-023 lc={1,1,3,4} → parse_err=1, opened_mask=8'h58, end timing unchanged.
REQ-024 lc={0,1,2,9} → parse_err=1, opened_mask=8'hE0.
- Z[1] reserved=1 with lc={0,1,2,3} → parse_err=1.
REQ-025 reset=1 at SCATTER j=4 → next cycle all outputs 0, state IDLE.
- Start held high → a full parse restarts and end rises 10 edges later.
REQ-026 start held high after end → outputs stable, no second parse.
- Start low for 1 cycle, then high with a new sigma → a new result appears 10 edges later.
